uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_if.sv | 39 +++
 rtl/uart_rx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if -- bundles the receiver-side write inputs, the consumer
// read handshake and the status outputs of uart_rx_fifo.
// Optional: define UART_RX_FIFO_OVF_CNT_EN to carry the 8-bit ovf_count.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_finished;
    logic                  rd_en;
    logic                  clr_ovf;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
`ifdef UART_RX_FIFO_OVF_CNT_EN
    logic [7:0]            ovf_count;
`endif

    // Producer/consumer side: drives receiver byte, read request and clear
    modport master (
        output rx_data, rx_finished, rd_en, clr_ovf,
        input  rd_data, rd_valid, empty, full, count, overflow
`ifdef UART_RX_FIFO_OVF_CNT_EN
        , input ovf_count
`endif
    );

    // FIFO side: consumes the strobes, returns data and status
    modport slave (
        input  rx_data, rx_finished, rd_en, clr_ovf,
        output rd_data, rd_valid, empty, full, count, overflow
`ifdef UART_RX_FIFO_OVF_CNT_EN
        , output ovf_count
`endif
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- receive FIFO behind a UART receiver. A byte is written on
// the rising edge of the receiver's is_finished level; the consumer pops the
// head with rd_en and gets it one cycle later qualified by rd_valid.
// Bytes arriving while full (and not being read) are dropped and flagged in
// the sticky overflow bit.
// Optional: define UART_RX_FIFO_OVF_CNT_EN to add a saturating 8-bit count
// of dropped bytes (ovf_count).
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_rx_fifo_if.slave      bus
);
    localparam int                   DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]  CNT_ZERO   = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]  CNT_ONE    = (DEPTH_LOG2+1)'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1'b1);

    // Storage is never reset: an entry is only observable after being written
    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  empty_r;
    logic                  full_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_valid_r;
    logic                  overflow_r;
    logic                  rx_fin_d_r;

    logic                  wr_stb_s;
    logic                  rd_ok_s;
    logic                  wr_acc_s;
    logic                  drop_s;
    logic [DEPTH_LOG2:0]   count_next_s;

    // Decode the write strobe, read qualification, accept/drop and next count
    always_comb begin
        wr_stb_s     = 1'b0;
        rd_ok_s      = 1'b0;
        wr_acc_s     = 1'b0;
        drop_s       = 1'b0;
        count_next_s = count_r;

        wr_stb_s = bus.rx_finished & ~rx_fin_d_r;
        rd_ok_s  = bus.rd_en & ~empty_r;
        // A read in the same cycle frees the head slot, so a full FIFO still accepts
        wr_acc_s = wr_stb_s & (~full_r | rd_ok_s);
        drop_s   = wr_stb_s & full_r & ~rd_ok_s;

        if (wr_acc_s && !rd_ok_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (rd_ok_s && !wr_acc_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers, occupancy and flags; empty/full are derived from the next count
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            // Start high so a receiver already reporting finished is not a new byte
            rx_fin_d_r <= 1'b1;
        end else begin
            rx_fin_d_r <= bus.rx_finished;
            count_r    <= count_next_s;
            empty_r    <= (count_next_s == CNT_ZERO);
            full_r     <= (count_next_s == FULL_COUNT);
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Byte storage write port
    always_ff @(posedge clk) begin
        if (reset_n && wr_acc_s) begin
            mem_r[wr_ptr_r] <= bus.rx_data;
        end
    end

    // Registered read port: head byte one cycle after an accepted rd_en, held otherwise
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_r  <= {DATA_WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_ok_s;
            if (rd_ok_s) begin
                rd_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Sticky overflow: a new drop outranks a clear in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_r <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_OVF_CNT_EN
    logic [7:0] ovf_count_r;

    // Saturating drop counter; a clear coinciding with a drop restarts at one
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_count_r <= 8'd0;
        end else if (bus.clr_ovf) begin
            ovf_count_r <= drop_s ? 8'd1 : 8'd0;
        end else if (drop_s && (ovf_count_r != 8'hFF)) begin
            ovf_count_r <= ovf_count_r + 8'd1;
        end
    end

    assign bus.ovf_count = ovf_count_r;
`endif

    assign bus.rd_data  = rd_data_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.empty    = empty_r;
    assign bus.full     = full_r;
    assign bus.count    = count_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo -- directed scenarios plus randomized traffic for
// uart_rx_fifo, checked cycle by cycle against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DW = 8;
    localparam int DL = 4;
    localparam int DEPTH = 1 << DL;

    logic clk;
    logic reset_n;

    uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) bus ();

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] q[$];
    bit         m_prev_fin;
    bit         m_ovf;
    int         m_ovf_cnt;
    logic [7:0] m_rd_data;
    bit         m_rd_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the spec's rules on the current inputs
    task automatic model_step();
        bit strobe;
        bit can_read;
        bit was_full;
        bit drop;
        if (!reset_n) begin
            q.delete();
            m_prev_fin = 1'b1;
            m_ovf      = 1'b0;
            m_ovf_cnt  = 0;
            m_rd_data  = 8'h00;
            m_rd_valid = 1'b0;
        end else begin
            strobe   = bus.rx_finished && !m_prev_fin;
            was_full = (q.size() == DEPTH);
            can_read = bus.rd_en && (q.size() != 0);
            drop     = 1'b0;
            m_rd_valid = 1'b0;
            if (can_read) begin
                m_rd_data  = q.pop_front();
                m_rd_valid = 1'b1;
            end
            if (strobe) begin
                if (!was_full || can_read) q.push_back(bus.rx_data);
                else drop = 1'b1;
            end
            if (bus.clr_ovf) begin
                m_ovf     = drop;
                m_ovf_cnt = drop ? 1 : 0;
            end else if (drop) begin
                m_ovf     = 1'b1;
                m_ovf_cnt = (m_ovf_cnt < 255) ? m_ovf_cnt + 1 : 255;
            end
            m_prev_fin = bus.rx_finished;
        end
    endtask

    // Apply one cycle of inputs, clock it, then compare every output to the model
    task automatic step(input bit rst_n, input bit fin, input logic [7:0] d, input bit rd, input bit clr);
        reset_n         = rst_n;
        bus.rx_finished = fin;
        bus.rx_data     = d;
        bus.rd_en       = rd;
        bus.clr_ovf     = clr;
        model_step();
        @(posedge clk);
        #1;
        check_eq("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
        check_eq("rd_data",  32'(bus.rd_data),  32'(m_rd_data));
        check_eq("count",    32'(bus.count),    32'(q.size()));
        check_eq("empty",    32'(bus.empty),    32'(q.size() == 0));
        check_eq("full",     32'(bus.full),     32'(q.size() == DEPTH));
        check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_OVF_CNT_EN
        check_eq("ovf_count", 32'(bus.ovf_count), 32'(m_ovf_cnt));
`endif
    endtask

    task automatic pulse(input logic [7:0] d, input bit rd);
        step(1'b1, 1'b1, d, rd, 1'b0);
        step(1'b1, 1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        while (q.size() != 0) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
    endtask

    logic [7:0] first16[0:15];

    initial begin
        reset_n = 1'b0;
        bus.rx_finished = 1'b0;
        bus.rx_data = 8'h00;
        bus.rd_en = 1'b0;
        bus.clr_ovf = 1'b0;
        #2;

        // Reset with receiver already finished; release must not write
        step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        check_eq("no_write_at_release", 32'(bus.count), 32'd0);
        idle(2);

        // Three bytes, then rd_en held three cycles
        pulse(8'h41, 1'b0);
        pulse(8'h42, 1'b0);
        pulse(8'h43, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("abc_0", 32'(bus.rd_data), 32'h41);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("abc_1", 32'(bus.rd_data), 32'h42);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("abc_2", 32'(bus.rd_data), 32'h43);
        check_eq("abc_empty", 32'(bus.empty), 32'd1);
        // rd_en on empty is ignored and rd_data holds
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("rd_empty_hold", 32'(bus.rd_data), 32'h43);

        // Level held for 50 cycles gives exactly one write
        for (int i = 0; i < 50; i++) step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        check_eq("level_one_write", 32'(bus.count), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drain();

        // 17 writes: 16 stored, the 17th dropped
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (i < 16) first16[i] = b;
            pulse(b, 1'b0);
            if (i == 15) check_eq("full_after_16", 32'(bus.full), 32'd1);
        end
        check_eq("ovf_after_17", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            check_eq("order16", 32'(bus.rd_data), 32'(first16[i]));
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Full FIFO: write 0x99 together with a read
        for (int i = 0; i < 16; i++) pulse(8'(i + 8'h10), 1'b0);
        step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
        check_eq("full_rw_count", 32'(bus.count), 32'd16);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drain();
        check_eq("x99_last", 32'(bus.rd_data), 32'h99);

        // Mid-operation reset with five entries
        for (int i = 0; i < 5; i++) pulse(8'(i + 8'hC0), 1'b0);
        check_eq("count5", 32'(bus.count), 32'd5);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_empty", 32'(bus.empty), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("rst_no_valid", 32'(bus.rd_valid), 32'd0);

        // 300 drops then clear; also a drop coinciding with clr_ovf
        for (int i = 0; i < 16; i++) pulse(8'($urandom), 1'b0);
        for (int i = 0; i < 300; i++) pulse(8'($urandom), 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
        check_eq("drop_clr_set_wins", 32'(bus.overflow), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("clr_after_300", 32'(bus.overflow), 32'd0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit rst_n;
            rst_n = ($urandom_range(0, 299) != 0);
            step(rst_n, 1'($urandom), 8'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
